// File: rtl/ps2_host_tx.sv
// ps2_host_tx - host-to-device PS/2 command transmitter.
//
// Sends one command byte to a PS/2 device: holds the clock low to inhibit
// the device, issues the request-to-send (start bit), then shifts out the
// eight data bits LSB first, odd parity and the stop bit on the device's
// falling clock edges, and finally checks the device's acknowledge bit.
// Both PS/2 lines are driven open-drain: a 1 on a *_drive_low output pulls
// the line low, a 0 releases it.
//
// Ports:
//   CLOCK_50           system clock
//   reset              synchronous, active-high reset
//   send_cmd           one-cycle request, accepted only while busy=0
//   cmd_data[7:0]      byte to send, sampled on the accepting cycle
//   ps2_clk_in         raw PS2_CLK pin level
//   ps2_dat_in         raw PS2_DAT pin level
//   ps2_clk_drive_low  1 pulls PS2_CLK low
//   ps2_dat_drive_low  1 pulls PS2_DAT low
//   busy               transfer in progress
//   done               one-cycle pulse, device acknowledged
//   error              one-cycle pulse, timeout or missing acknowledge
//
// Optional feature macro: PS2_HOST_TX_RETRY_EN
//   When defined, the first failure of a request silently restarts the
//   whole sequence once with the same byte; only a second failure pulses
//   error. When undefined, the first failure pulses error.

module ps2_host_tx #(
  parameter int unsigned CLK_INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT      = 750000,
  parameter int unsigned FRAME_TIMEOUT      = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send_cmd,
  input  logic [7:0] cmd_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT_EDGE,
    S_SHIFT,
    S_WAIT_IDLE,
    S_ERROR
  } state_t;

  localparam logic [19:0] INHIBIT_LAST = 20'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] FRAME_LAST   = 20'(FRAME_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        parity_q, parity_d;
  logic        clk_drv_q, clk_drv_d;
  logic        dat_drv_q, dat_drv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        clk_meta_q, clk_meta_d;
  logic        clk_sync_q, clk_sync_d;
  logic        clk_prev_q, clk_prev_d;
  logic        dat_meta_q, dat_meta_d;
  logic        dat_sync_q, dat_sync_d;

`ifdef PS2_HOST_TX_RETRY_EN
  logic        retry_q, retry_d;
`endif

  logic        fall;
  logic        fail;
  logic [19:0] cnt_inc;

  // Two-flop synchronizers plus one history flop for falling-edge detection.
  always_comb begin
    clk_meta_d = ps2_clk_in;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = ps2_dat_in;
    dat_sync_d = dat_meta_q;
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // The shared counter saturates so an equality timeout test cannot be skipped.
  assign cnt_inc = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    parity_d  = parity_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fail      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (send_cmd) begin
          cmd_d     = cmd_data;
          parity_d  = ~^cmd_data;
          cnt_d     = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          clk_drv_d = 1'b1;
          state_d   = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d   = 1'b0;
`endif
        end
      end

      S_INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == INHIBIT_LAST) begin
          dat_drv_d = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        clk_drv_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_WAIT_EDGE;
      end

      S_WAIT_EDGE: begin
        if (fall) begin
          dat_drv_d = ~cmd_q[0];
          bit_cnt_d = 4'd1;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end else if (cnt_q == START_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // bit_cnt_q holds the number of falls already seen, so the fall being
      // handled now is number bit_cnt_q+1 and data bit bit_cnt_q goes out.
      S_SHIFT: begin
        cnt_d = cnt_inc;
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd7) begin
            dat_drv_d = ~cmd_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            dat_drv_d = ~parity_q;
          end else if (bit_cnt_q == 4'd9) begin
            dat_drv_d = 1'b0;
          end else if (!dat_sync_q) begin
            cnt_d   = '0;
            state_d = S_WAIT_IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (cnt_q == FRAME_LAST) begin
          fail = 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == FRAME_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_ERROR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any failure releases both lines and pulses error while dropping busy.
    // With retries enabled the first failure instead restarts the inhibit.
    if (fail) begin
      state_d   = S_ERROR;
      error_d   = 1'b1;
      busy_d    = 1'b0;
      clk_drv_d = 1'b0;
      dat_drv_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        state_d   = S_INHIBIT;
        error_d   = 1'b0;
        busy_d    = 1'b1;
        clk_drv_d = 1'b1;
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
`endif
    end
  end

  // State register with synchronous reset; synchronizers idle high.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      parity_q   <= 1'b0;
      clk_drv_q  <= 1'b0;
      dat_drv_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      parity_q   <= parity_d;
      clk_drv_q  <= clk_drv_d;
      dat_drv_q  <= dat_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign ps2_clk_drive_low = clk_drv_q;
  assign ps2_dat_drive_low = dat_drv_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx - directed self-checking bench for ps2_host_tx.
//
// A behavioural PS/2 device shares open-drain lines with the DUT, clocks
// at a 40-cycle period and acknowledges by holding data low at edge 11.
// Expected line values per frame are hand-computed constants.

module tb_ps2_host_tx;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       send_cmd;
  logic [7:0] cmd_data;
  logic       ps2_clk_drive_low;
  logic       ps2_dat_drive_low;
  logic       busy;
  logic       done;
  logic       error;

  logic       devClkLow = 1'b0;
  logic       devDatLow = 1'b0;
  logic       clkLine;
  logic       datLine;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int errorCount  = 0;
  int bothCount   = 0;
  int runLen      = 0;
  int runBoth     = 0;
  int lastRun     = 0;
  int lastBoth    = 0;
  int runCount    = 0;

  // Wired-AND bus: a line is high only when nobody pulls it low.
  assign clkLine = ~(ps2_clk_drive_low | devClkLow);
  assign datLine = ~(ps2_dat_drive_low | devDatLow);

  ps2_host_tx #(
    .CLK_INHIBIT_CYCLES(20),
    .START_TIMEOUT(400),
    .FRAME_TIMEOUT(2000)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .send_cmd(send_cmd),
    .cmd_data(cmd_data),
    .ps2_clk_in(clkLine),
    .ps2_dat_in(datLine),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_dat_drive_low(ps2_dat_drive_low),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // 100 MHz-style free-running bench clock; period is irrelevant to the DUT.
  always #5 CLOCK_50 = ~CLOCK_50;

  // Count result pulses and any cycle where both pulses are high together.
  always @(negedge CLOCK_50) begin
    if (done) doneCount++;
    if (error) errorCount++;
    if (done && error) bothCount++;
  end

  // Measure each contiguous run of the host pulling the clock low, and how
  // many of those cycles also had the data line pulled low (request phase).
  always @(negedge CLOCK_50) begin
    if (ps2_clk_drive_low) begin
      runLen++;
      if (ps2_dat_drive_low) runBoth++;
    end else if (runLen != 0) begin
      lastRun  = runLen;
      lastBoth = runBoth;
      runCount++;
      runLen   = 0;
      runBoth  = 0;
    end
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse send_cmd for exactly one clock with the given byte.
  task automatic applyStimulus(input logic [7:0] data);
    @(negedge CLOCK_50);
    send_cmd = 1'b1;
    cmd_data = data;
    @(negedge CLOCK_50);
    send_cmd = 1'b0;
  endtask

  // Device side of one frame. Waits for the host to release the clock, then
  // generates 11 falling edges and records the data line just before each
  // rising edge. abortEdge>0 applies a reset during that edge instead.
  task automatic deviceFrame(input logic ack, input int abortEdge, input bit inject,
                             output logic [10:0] seen, output bit ok);
    int n;
    seen = '0;
    ok   = 1'b0;
    n    = 0;
    while (!ps2_clk_drive_low && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    while (ps2_clk_drive_low && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 400) return;
    repeat (10) @(negedge CLOCK_50);
    for (int k = 1; k <= 11; k++) begin
      devClkLow = 1'b1;
      if (k == abortEdge) begin
        repeat (6) @(negedge CLOCK_50);
        checkOutput("busyBeforeReset", busy, 1);
        checkOutput("datBeforeReset", ps2_dat_drive_low, 1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstClkDrive", ps2_clk_drive_low, 0);
        checkOutput("rstDatDrive", ps2_dat_drive_low, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstError", error, 0);
        reset     = 1'b0;
        devClkLow = 1'b0;
        ok        = 1'b1;
        return;
      end
      for (int i = 0; i < 19; i++) begin
        @(negedge CLOCK_50);
        if (inject && k == 3 && i == 5) begin
          send_cmd = 1'b1;
          cmd_data = 8'h00;
        end else begin
          send_cmd = 1'b0;
        end
      end
      seen[k-1] = datLine;
      @(negedge CLOCK_50);
      devClkLow = 1'b0;
      if (k == 11) begin
        if (ack) begin
          repeat (5) @(negedge CLOCK_50);
          devDatLow = 1'b0;
        end
        ok = 1'b1;
        return;
      end
      if (k == 10 && ack) begin
        repeat (10) @(negedge CLOCK_50);
        devDatLow = 1'b1;
        repeat (10) @(negedge CLOCK_50);
      end else begin
        repeat (20) @(negedge CLOCK_50);
      end
    end
  endtask

  // Bounded wait for done or error.
  task automatic waitPulse(output bit sawDone, output bit sawError);
    int cycles;
    cycles = 0;
    while (!done && !error && cycles < 3000) begin
      @(negedge CLOCK_50);
      cycles++;
    end
    sawDone  = done;
    sawError = error;
  endtask

  // Directed test sequence.
  initial begin
    logic [10:0] seen;
    bit          ok;
    bit          sawDone;
    bit          sawError;
    int          d0;
    int          e0;
    int          r0;
    int          n;
    int          releases;

    reset    = 1'b1;
    send_cmd = 1'b0;
    cmd_data = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    checkOutput("resetClkDrive", ps2_clk_drive_low, 0);
    checkOutput("resetDatDrive", ps2_dat_drive_low, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetError", error, 0);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    $display("[TB] 0xED transfer");
    d0 = doneCount;
    applyStimulus(8'hED);
    checkOutput("edBusyAfterAccept", busy, 1);
    deviceFrame(1'b1, 0, 1'b0, seen, ok);
    checkOutput("edFrameOk", ok, 1);
    checkOutput("edLineBits", seen, 32'h3ED);
    checkOutput("edInhibitCycles", lastRun - lastBoth, 20);
    checkOutput("edReqCycles", lastBoth, 1);
    waitPulse(sawDone, sawError);
    checkOutput("edDone", sawDone, 1);
    checkOutput("edBusyAtDone", busy, 0);
    repeat (20) @(negedge CLOCK_50);
    checkOutput("edDoneCount", doneCount - d0, 1);

    $display("[TB] 0xF4 transfer");
    d0 = doneCount;
    applyStimulus(8'hF4);
    deviceFrame(1'b1, 0, 1'b0, seen, ok);
    checkOutput("f4FrameOk", ok, 1);
    checkOutput("f4LineBits", seen, 32'h2F4);
    waitPulse(sawDone, sawError);
    checkOutput("f4Done", sawDone, 1);
    repeat (20) @(negedge CLOCK_50);
    checkOutput("f4DoneCount", doneCount - d0, 1);

    $display("[TB] device never clocks");
    d0 = doneCount;
    e0 = errorCount;
    applyStimulus(8'hA5);
    releases = 1;
`ifdef PS2_HOST_TX_RETRY_EN
    releases = 2;
`endif
    for (int r = 0; r < releases; r++) begin
      n = 0;
      while (!ps2_clk_drive_low && n < 1000) begin
        @(negedge CLOCK_50);
        n++;
      end
      while (ps2_clk_drive_low && n < 1000) begin
        @(negedge CLOCK_50);
        n++;
      end
    end
    n = 0;
    while (!error && n < 1000) begin
      @(negedge CLOCK_50);
      n++;
    end
    checkOutput("ncErrorDelay", n, 400);
    checkOutput("ncClkReleased", ps2_clk_drive_low, 0);
    checkOutput("ncDatReleased", ps2_dat_drive_low, 0);
    checkOutput("ncBusyAtError", busy, 0);
    repeat (10) @(negedge CLOCK_50);
    checkOutput("ncNoDone", doneCount - d0, 0);
    checkOutput("ncErrorCount", errorCount - e0, 1);

    $display("[TB] missing acknowledge");
    d0 = doneCount;
    e0 = errorCount;
    r0 = runCount;
    applyStimulus(8'hF4);
    deviceFrame(1'b0, 0, 1'b0, seen, ok);
    checkOutput("nackFrameOk", ok, 1);
`ifdef PS2_HOST_TX_RETRY_EN
    deviceFrame(1'b1, 0, 1'b0, seen, ok);
    checkOutput("retryFrameOk", ok, 1);
    checkOutput("retryLineBits", seen, 32'h2F4);
    waitPulse(sawDone, sawError);
    checkOutput("retryDone", sawDone, 1);
    repeat (20) @(negedge CLOCK_50);
    checkOutput("retryInhibitRuns", runCount - r0, 2);
    checkOutput("retryInhibitCycles", lastRun - lastBoth, 20);
    checkOutput("retryDoneCount", doneCount - d0, 1);
    checkOutput("retryNoError", errorCount - e0, 0);
`else
    repeat (20) @(negedge CLOCK_50);
    checkOutput("nackErrorCount", errorCount - e0, 1);
    checkOutput("nackNoDone", doneCount - d0, 0);
    checkOutput("nackBusy", busy, 0);
    checkOutput("nackInhibitRuns", runCount - r0, 1);
`endif

    $display("[TB] reset at edge 5, then 0xFF");
    d0 = doneCount;
    e0 = errorCount;
    applyStimulus(8'hED);
    deviceFrame(1'b1, 5, 1'b0, seen, ok);
    checkOutput("abortFrameOk", ok, 1);
    repeat (10) @(negedge CLOCK_50);
    checkOutput("abortNoDone", doneCount - d0, 0);
    checkOutput("abortNoError", errorCount - e0, 0);
    applyStimulus(8'hFF);
    deviceFrame(1'b1, 0, 1'b0, seen, ok);
    checkOutput("ffFrameOk", ok, 1);
    checkOutput("ffLineBits", seen, 32'h3FF);
    waitPulse(sawDone, sawError);
    checkOutput("ffDone", sawDone, 1);
    repeat (20) @(negedge CLOCK_50);
    checkOutput("ffDoneCount", doneCount - d0, 1);

    $display("[TB] send_cmd while busy");
    d0 = doneCount;
    r0 = runCount;
    applyStimulus(8'hED);
    deviceFrame(1'b1, 0, 1'b1, seen, ok);
    checkOutput("injFrameOk", ok, 1);
    checkOutput("injLineBits", seen, 32'h3ED);
    waitPulse(sawDone, sawError);
    checkOutput("injDone", sawDone, 1);
    repeat (100) @(negedge CLOCK_50);
    checkOutput("injDoneCount", doneCount - d0, 1);
    checkOutput("injInhibitRuns", runCount - r0, 1);
    checkOutput("injIdleAfter", busy, 0);

    checkOutput("neverDoneAndError", bothCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset).
- Pairs with the existing PS/2 receive path on the same PS2_CLK/PS2_DAT pins.
- Drives the lines open-drain through two pull-low enables; the top level ties each inout to 1'bz or 1'b0.
- Runs the full request-to-send, shift, stop and acknowledge sequence, with timeouts.

Parameters:
- CLK_INHIBIT_CYCLES, 5000: CLOCK_50 cycles PS2_CLK is held low before the start bit (100 us at 50 MHz).
- START_TIMEOUT, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000: maximum cycles from the first falling edge to the ack edge (2 ms).

Ports:
- CLOCK_50  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- send_cmd  in  1: one-cycle request; accepted only when busy=0.
- cmd_data  in  8: byte to send; sampled on the accepting cycle.
- ps2_clk_in  in  1: raw PS2_CLK pin level.
- ps2_dat_in  in  1: raw PS2_DAT pin level.
- ps2_clk_drive_low  out  1: 1 pulls PS2_CLK low, 0 releases it.
- ps2_dat_drive_low  out  1: 1 pulls PS2_DAT low, 0 releases it.
- busy  out  1: transfer in progress.
- done  out  1: one-cycle pulse, device acknowledged.
- error  out  1: one-cycle pulse, timeout or missing ack.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 on the next CLOCK_50 edge; lines are released; state returns to IDLE.
  - This applies mid-transfer as well; no done or error pulse is issued.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
  - fall = (previous synchronized clk == 1) && (current == 0).
  - Falling edges are seen 3 cycles after the pin transition.
- IDLE:
  - Both drive_low outputs are 0.
  - send_cmd=1 latches cmd_data and parity = ~^cmd_data (odd parity), clears the counters, sets busy=1 and ps2_clk_drive_low=1 on the next cycle, then goes to INHIBIT.
- INHIBIT:
  - Clock is held low for exactly CLK_INHIBIT_CYCLES cycles.
  - Then ps2_dat_drive_low=1 (start bit) and go to REQ.
- REQ:
  - One cycle with both lines low.
  - Then ps2_clk_drive_low=0 and go to WAIT_EDGE.
- WAIT_EDGE:
  - The first fall goes to SHIFT with bit index k=1.
  - START_TIMEOUT cycles with no fall → ERROR.
- SHIFT: on each fall k the data line is updated in the following cycle.
  - k=1..8: ps2_dat_drive_low = ~cmd_data[k-1] (LSB first).
  - k=9: ps2_dat_drive_low = ~parity.
  - k=10: ps2_dat_drive_low = 0 (stop bit, line released).
  - k=11: sample the synchronized dat. 0 = ack → WAIT_IDLE; 1 → ERROR.
  - The frame counter runs from the first fall; reaching FRAME_TIMEOUT before k=11 → ERROR.
- WAIT_IDLE:
  - Wait until synchronized clk=1 and dat=1 (device releases ack).
  - Then done=1 for one cycle, busy=0 in that same cycle, go to IDLE.
  - This state is also bounded by FRAME_TIMEOUT → ERROR.
- ERROR:
  - Both lines released, error=1 for one cycle, busy=0 in that cycle, go to IDLE.
- Concurrency and ordering:
  - send_cmd while busy=1 is ignored; nothing is queued.
  - done and error are never asserted together.
  - A new send_cmd is accepted the cycle after the done or error pulse.
- Widths: 20-bit counters, sufficient for 750000; the counter saturates rather than wrapping.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On the first error of a request (missing ack or any timeout), no error pulse is issued.
  - The FSM re-enters INHIBIT with the same latched byte and busy held at 1.
  - The second failure issues error; success on the retry issues done.
  - A 1-bit retry flag is cleared on each new accept.
- Undefined: the first failure issues error immediately; no retry logic is synthesized.

Test Plan:
- Bench parameters CLK_INHIBIT_CYCLES=20, START_TIMEOUT=400, FRAME_TIMEOUT=2000. Device model clocks at a 40-cycle period and acks with dat low at edge 11.
- send_cmd with cmd_data=0xED:
  - clk_drive_low is high for exactly 20 cycles, then both lines are low for 1 cycle.
  - Bits driven after edges 1–8 are 1,0,1,1,0,1,1,1; parity is 1; stop is released.
  - done pulses once; busy falls in the same cycle.
- cmd_data=0xF4: data bits 0,0,1,0,1,1,1,1, parity 0, done pulse.
- Device never clocks: error pulses exactly 400 cycles after clock release; both lines released; done stays 0.
- Device leaves dat high at edge 11: error pulses. With PS2_HOST_TX_RETRY_EN, a second full INHIBIT phase occurs instead; an ack on the retry gives done.
- Reset asserted at edge 5 of a transfer:
  - Next cycle: busy=0, both drive_low=0, no done or error.
  - A subsequent send_cmd of 0xFF completes with done.
- send_cmd pulsed again mid-transfer with 0x00: ignored; the original byte completes and exactly one done pulse occurs.
